// File: rtl/ucup_mem_pkg.sv
// Shared types and widths for the external-memory arbiter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ucup_mem_pkg;

    localparam int unsigned MEM_AW         = 32;
    localparam int unsigned MEM_DW         = 32;
    localparam int unsigned MEM_BEW        = 4;
    localparam int unsigned NUM_PORTS_DFLT = 2;

    // Port-index width, never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [id_width(NUM_PORTS_DFLT)-1:0] port_id_t;

    // Address-phase fields of one request, bundled so the winner mux is one assignment.
    typedef struct packed {
        logic               we;
        logic [MEM_BEW-1:0] be;
        logic [MEM_AW-1:0]  addr;
        logic [MEM_DW-1:0]  wdata;
    } mem_req_t;

endpackage

// File: rtl/ucup_id_fifo.sv
// Purpose: in-order FIFO of port IDs for transactions awaiting a memory response.
// Latency: push visible at head one cycle later; pop takes effect at the next edge.
// Backpressure: full_o/empty_o are count-based; pushes when full and pops when empty are dropped.
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset (empties the FIFO)
//   push_i, data_i    enqueue one ID
//   pop_i, head_o     dequeue; head_o is the oldest entry
//   full_o, empty_o   occupancy flags
module ucup_id_fifo #(
    parameter int unsigned Depth = 2,
    parameter type         id_t  = logic
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  id_t  data_i,
    input  logic pop_i,
    output id_t  head_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    id_t            mem_q [Depth];
    logic [PtrW-1:0] wr_q, wr_d;
    logic [PtrW-1:0] rd_q, rd_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_d  = do_push ? ptr_inc(wr_q) : wr_q;
        rd_d  = do_pop  ? ptr_inc(rd_q) : rd_q;
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/ucup_mem_arbiter.sv
// Purpose: round-robin share of one SRAM port among NumPorts requesters, responses routed in order.
// Latency: zero added cycles on both grant and response paths; at most one grant per cycle.
// Backpressure: m_gnt_i low holds the winner; a full ID FIFO drops m_req_o (no same-cycle bypass).
//
// Ports: clk_sys_i/rst_sys_i (sync active-high reset); s_* per-port request/grant/response;
//        m_* single memory port; err_o sticky spurious-response flag; perf_* counters.
// Optional: define UCUP_MEM_ARB_PERF_EN to build the per-port grant/stall counters,
//           otherwise perf_gnt_o/perf_stall_o are tied to zero.
module ucup_mem_arbiter
    import ucup_mem_pkg::*;
#(
    parameter int unsigned NumPorts       = NUM_PORTS_DFLT,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                              clk_sys_i,
    input  logic                              rst_sys_i,
    input  logic [NumPorts-1:0]               s_req_i,
    output logic [NumPorts-1:0]               s_gnt_o,
    input  logic [NumPorts-1:0]               s_we_i,
    input  logic [NumPorts-1:0][MEM_BEW-1:0]  s_be_i,
    input  logic [NumPorts-1:0][MEM_AW-1:0]   s_addr_i,
    input  logic [NumPorts-1:0][MEM_DW-1:0]   s_wdata_i,
    output logic [NumPorts-1:0]               s_rvalid_o,
    output logic [NumPorts-1:0][MEM_DW-1:0]   s_rdata_o,
    output logic                              m_req_o,
    input  logic                              m_gnt_i,
    output logic                              m_we_o,
    output logic [MEM_BEW-1:0]                m_be_o,
    output logic [MEM_AW-1:0]                 m_addr_o,
    output logic [MEM_DW-1:0]                 m_wdata_o,
    input  logic                              m_rvalid_i,
    input  logic [MEM_DW-1:0]                 m_rdata_i,
    output logic                              err_o,
    output logic [NumPorts-1:0][31:0]         perf_gnt_o,
    output logic [NumPorts-1:0][31:0]         perf_stall_o
);

    localparam int unsigned IdW = id_width(NumPorts);
    typedef logic [IdW-1:0] id_t;

    id_t      rr_q, rr_d;
    id_t      win;
    id_t      head;
    logic     any_req;
    logic     fifo_full, fifo_empty;
    logic     hs, pop;
    logic     err_q, err_d;
    mem_req_t win_req;

    // Winner: first requester at or after rr_q, wrapping modulo NumPorts.
    always_comb begin
        int unsigned idx;
        logic        found;
        idx   = 0;
        found = 1'b0;
        win   = rr_q;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NumPorts) begin
                idx = idx - NumPorts;
            end
            if (!found && s_req_i[idx]) begin
                found = 1'b1;
                win   = id_t'(idx);
            end
        end
    end

    assign any_req = |s_req_i;
    assign m_req_o = any_req & ~fifo_full;
    assign hs      = m_req_o & m_gnt_i;
    // Responses with nothing outstanding are not popped; they only raise err_o.
    assign pop     = m_rvalid_i & ~fifo_empty;

    always_comb begin
        win_req = '0;
        if (any_req) begin
            win_req.we    = s_we_i[win];
            win_req.be    = s_be_i[win];
            win_req.addr  = s_addr_i[win];
            win_req.wdata = s_wdata_i[win];
        end
    end

    assign m_we_o    = win_req.we;
    assign m_be_o    = win_req.be;
    assign m_addr_o  = win_req.addr;
    assign m_wdata_o = win_req.wdata;

    always_comb begin
        s_gnt_o = '0;
        if (hs) begin
            s_gnt_o[win] = 1'b1;
        end
    end

    always_comb begin
        s_rvalid_o = '0;
        if (pop) begin
            s_rvalid_o[head] = 1'b1;
        end
    end

    assign s_rdata_o = {NumPorts{m_rdata_i}};

    // Pointer only advances on an accepted handshake so a stalled winner keeps priority.
    always_comb begin
        rr_d = rr_q;
        if (hs) begin
            rr_d = (win == id_t'(NumPorts - 1)) ? '0 : win + id_t'(1);
        end
    end

    assign err_d = err_q | (m_rvalid_i & fifo_empty);
    assign err_o = err_q;

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            rr_q  <= '0;
            err_q <= 1'b0;
        end else begin
            rr_q  <= rr_d;
            err_q <= err_d;
        end
    end

    ucup_id_fifo #(
        .Depth (MaxOutstanding),
        .id_t  (id_t)
    ) u_id_fifo (
        .clk_i   (clk_sys_i),
        .rst_i   (rst_sys_i),
        .push_i  (hs),
        .data_i  (win),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef UCUP_MEM_ARB_PERF_EN
    logic [NumPorts-1:0][31:0] gnt_cnt_q, gnt_cnt_d;
    logic [NumPorts-1:0][31:0] stall_cnt_q, stall_cnt_d;

    // Saturating counters: hold at all-ones rather than wrap.
    always_comb begin
        gnt_cnt_d   = gnt_cnt_q;
        stall_cnt_d = stall_cnt_q;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            if (s_gnt_o[i] && (gnt_cnt_q[i] != 32'hFFFF_FFFF)) begin
                gnt_cnt_d[i] = gnt_cnt_q[i] + 32'd1;
            end
            if (s_req_i[i] && !s_gnt_o[i] && (stall_cnt_q[i] != 32'hFFFF_FFFF)) begin
                stall_cnt_d[i] = stall_cnt_q[i] + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            gnt_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            gnt_cnt_q   <= gnt_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_gnt_o   = gnt_cnt_q;
    assign perf_stall_o = stall_cnt_q;
`else
    assign perf_gnt_o   = '0;
    assign perf_stall_o = '0;
`endif

endmodule
